// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and constants for the multicycle multiply/divide unit
package multdiv_pkg;

  localparam int MULTDIV_WIDTH = 32;
  localparam int MULTDIV_ITERS = 32;
  localparam int MULTDIV_CNT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MULT   = 2'd1,
    ST_DIV    = 2'd2,
    ST_FINISH = 2'd3
  } multdiv_state_e;

endpackage

// File: rtl/multdiv_div_step.sv
// rtl/multdiv_div_step.sv - one combinational restoring-division step on magnitudes
module multdiv_div_step
  import multdiv_pkg::*;
#(
  parameter int W = MULTDIV_WIDTH
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] divisor_i,
  input  logic         bit_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0]   shifted;
  logic [W-1:0] reduced;

  // Partial remainder stays below the divisor, so the subtraction fits in W bits.
  assign shifted = {rem_i, bit_i};
  assign q_o     = (shifted >= {1'b0, divisor_i});
  assign reduced = shifted[W-1:0] - divisor_i;
  assign rem_o   = q_o ? reduced : shifted[W-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed Booth multiply / restoring divide; MULTDIV_DIVZERO_EN adds early div-by-zero exit
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MULTDIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  multdiv_state_e           state_q, state_d;
  logic [MULTDIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]           acc_q, acc_d;
  logic [WIDTH-1:0]         quo_q, quo_d;
  logic                     qm1_q, qm1_d;
  logic [WIDTH-1:0]         opnd_q, opnd_d;
  logic                     neg_quo_q, neg_quo_d;
  logic                     neg_rem_q, neg_rem_d;
  logic                     is_div_q, is_div_d;
  logic [WIDTH-1:0]         hi_q, hi_d;
  logic [WIDTH-1:0]         lo_q, lo_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [WIDTH:0]           booth_sum;
  logic [WIDTH:0]           mcand_ext;
  logic [WIDTH-1:0]         a_mag, b_mag;
  logic [WIDTH-1:0]         step_rem;
  logic                     step_q;
  logic                     write_en;
  logic                     last_iter;

`ifdef MULTDIV_DIVZERO_EN
  logic dz_q, dz_d;
  logic div_zero_q, div_zero_d;
`endif

  assign a_mag     = a_in[WIDTH-1] ? ({WIDTH{1'b0}} - a_in) : a_in;
  assign b_mag     = b_in[WIDTH-1] ? ({WIDTH{1'b0}} - b_in) : b_in;
  assign mcand_ext = {opnd_q[WIDTH-1], opnd_q};
  assign last_iter = (cnt_q == MULTDIV_CNT_W'(MULTDIV_ITERS - 1));

  // Divide shifts the dividend magnitude out of quo_q's MSB while quotient bits enter at the LSB.
  multdiv_div_step #(.W(WIDTH)) u_div_step (
    .rem_i     (acc_q[WIDTH-1:0]),
    .divisor_i (opnd_q),
    .bit_i     (quo_q[WIDTH-1]),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

`ifdef MULTDIV_DIVZERO_EN
  assign write_en = ~dz_q;
`else
  assign write_en = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    qm1_d     = qm1_q;
    opnd_d    = opnd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    booth_sum = acc_q;
`ifdef MULTDIV_DIVZERO_EN
    dz_d      = dz_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (start_mult) begin
          state_d  = ST_MULT;
          cnt_d    = '0;
          acc_d    = '0;
          quo_d    = b_in;
          qm1_d    = 1'b0;
          opnd_d   = a_in;
          is_div_d = 1'b0;
`ifdef MULTDIV_DIVZERO_EN
          dz_d     = 1'b0;
`endif
        end else if (start_div) begin
          state_d   = ST_DIV;
          cnt_d     = '0;
          acc_d     = '0;
          quo_d     = a_mag;
          qm1_d     = 1'b0;
          opnd_d    = b_mag;
          neg_quo_d = a_in[WIDTH-1] ^ b_in[WIDTH-1];
          neg_rem_d = a_in[WIDTH-1];
          is_div_d  = 1'b1;
`ifdef MULTDIV_DIVZERO_EN
          dz_d      = (b_in == '0);
          if (b_in == '0) state_d = ST_FINISH;
`endif
        end
      end

      ST_MULT: begin
        unique case ({quo_q[0], qm1_q})
          2'b01:   booth_sum = acc_q + mcand_ext;
          2'b10:   booth_sum = acc_q - mcand_ext;
          default: booth_sum = acc_q;
        endcase
        acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        quo_d = {booth_sum[0], quo_q[WIDTH-1:1]};
        qm1_d = quo_q[0];
        cnt_d = cnt_q + MULTDIV_CNT_W'(1);
        if (last_iter) state_d = ST_FINISH;
      end

      ST_DIV: begin
        acc_d = {1'b0, step_rem};
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q + MULTDIV_CNT_W'(1);
        if (last_iter) state_d = ST_FINISH;
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
        if (write_en) begin
          if (is_div_q) begin
            lo_d = neg_quo_q ? ({WIDTH{1'b0}} - quo_q) : quo_q;
            hi_d = neg_rem_q ? ({WIDTH{1'b0}} - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
          end else begin
            hi_d = acc_q[WIDTH-1:0];
            lo_d = quo_q;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);
  assign done_d = (state_q == ST_FINISH);
`ifdef MULTDIV_DIVZERO_EN
  assign div_zero_d = (state_q == ST_FINISH) && dz_q;
`endif

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      quo_q      <= '0;
      qm1_q      <= 1'b0;
      opnd_q     <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      is_div_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MULTDIV_DIVZERO_EN
      dz_q       <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      quo_q      <= quo_d;
      qm1_q      <= qm1_d;
      opnd_q     <= opnd_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      is_div_q   <= is_div_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef MULTDIV_DIVZERO_EN
      dz_q       <= dz_d;
      div_zero_q <= div_zero_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
`ifdef MULTDIV_DIVZERO_EN
  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit (honours MULTDIV_DIVZERO_EN)
module tb_mult_div_unit;

  localparam int W = 32;
`ifdef MULTDIV_DIVZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic         clk        = 1'b0;
  logic         reset_in   = 1'b0;
  logic         start_mult = 1'b0;
  logic         start_div  = 1'b0;
  logic [W-1:0] a_in       = '0;
  logic [W-1:0] b_in       = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi_out, lo_out;

  int           checks       = 0;
  int           errors       = 0;
  int           done_seen    = 0;
  int           ops_expected = 0;
  logic [64:0]  exp_q[$];
  logic [64:0]  mon_e;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk        (clk),
    .reset_in   (reset_in),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a_in       (a_in),
    .b_in       (b_in),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {div_zero, hi, lo} from plain arithmetic, with the architectural corner cases spelled out.
  function automatic logic [64:0] model(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] p;
    logic [W-1:0] q, r;
    if (is_mult) begin
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      return {1'b0, p};
    end
    if (b == '0) begin
      if (DZ_EN) return {1'b1, last_hi, last_lo};
      q = a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
      r = a;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
    return {1'b0, r, q};
  endfunction

  always @(negedge clk) begin
    if (reset_in && done) begin
      done_seen++;
      check_eq("done_expected", {63'd0, done}, {63'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_eq("hi", {32'd0, hi_out}, {32'd0, mon_e[63:32]});
        check_eq("lo", {32'd0, lo_out}, {32'd0, mon_e[31:0]});
        check_eq("div_zero", {63'd0, div_zero}, {63'd0, mon_e[64]});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the done cycle so the next start can go out back-to-back.
  task automatic run_op(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b, input int inject_at);
    logic [64:0] e;
    int lat, cyc;
    bit got;
    e   = model(m, a, b);
    lat = (!m && b == '0 && DZ_EN) ? 2 : 34;
    exp_q.push_back(e);
    ops_expected++;
    start_mult = m;
    start_div  = d;
    a_in       = a;
    b_in       = b;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 60) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        start_mult = 1'b0;
        start_div  = 1'b0;
        a_in       = $urandom;
        b_in       = $urandom;
        check_eq("busy_c1", {63'd0, busy}, 64'd1);
      end
      if (cyc == inject_at) start_div = 1'b1;
      else if (cyc == inject_at + 1) start_div = 1'b0;
      if (cyc == 20) begin
        check_eq("hold_hi", {32'd0, hi_out}, {32'd0, last_hi});
        check_eq("hold_lo", {32'd0, lo_out}, {32'd0, last_lo});
      end
      if (cyc == lat - 1) check_eq("busy_last", {63'd0, busy}, 64'd1);
      if (done) begin
        got = 1'b1;
        check_eq("latency", 64'(cyc), 64'(lat));
        check_eq("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
    if (!got) check_eq("timeout", 64'(cyc), 64'(lat));
    last_hi = e[63:32];
    last_lo = e[31:0];
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_dz", {63'd0, div_zero}, 64'd0);
    check_eq("rst_hi", {32'd0, hi_out}, 64'd0);
    check_eq("rst_lo", {32'd0, lo_out}, 64'd0);
    reset_in = 1'b1;
    @(posedge clk);
    #1;

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1);
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, -1);
    run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 10);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(1'b0, 1'b1, 32'd5, 32'd0, -1);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFB, 32'd0, -1);
    run_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, -1);
    run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, -1);
    for (int i = 0; i < 8; i++) begin
      logic mm;
      logic [W-1:0] ra, rb;
      mm = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      run_op(mm, ~mm, ra, rb, -1);
    end

    start_mult = 1'b1;
    a_in       = 32'd3;
    b_in       = 32'd4;
    @(posedge clk);
    #1;
    start_mult = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    reset_in = 1'b0;
    #1;
    check_eq("midrst_busy", {63'd0, busy}, 64'd0);
    check_eq("midrst_done", {63'd0, done}, 64'd0);
    check_eq("midrst_hi", {32'd0, hi_out}, 64'd0);
    check_eq("midrst_lo", {32'd0, lo_out}, 64'd0);
    @(posedge clk);
    #1;
    reset_in = 1'b1;
    last_hi  = '0;
    last_lo  = '0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("idle_after_rst", {63'd0, busy}, 64'd0);

    check_eq("done_count", 64'(done_seen), 64'(ops_expected));
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

- Multicycle signed multiply/divide unit for the MIPS multicycle datapath.
- Responder to the control unit: the control unit issues a one-cycle start with operands taken from registers A and B, and this block runs the iterative algorithm.
- Signals completion with a one-cycle `done`, then holds the HI/LO results for `mfhi`/`mflo`.
- Removes the need for the control unit to sequence the 32 iteration steps itself.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits.
- `clk` input 1: single clock, rising edge.
- `reset_in` input 1: asynchronous, active-low reset.
- `start_mult` input 1: one-cycle request for signed multiply of `a_in` × `b_in`.
- `start_div` input 1: one-cycle request for signed divide, `a_in` / `b_in`.
- `a_in` input WIDTH: operand A (dividend or multiplicand), sampled only on an accepted start.
- `b_in` input WIDTH: operand B (divisor or multiplier), sampled only on an accepted start.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse; HI/LO are valid from that cycle onward.
- `div_zero` output 1: one-cycle pulse on division by zero (only when `MULTDIV_DIVZERO_EN` is defined).
- `hi_out` output WIDTH: multiply upper word, or divide remainder.
- `lo_out` output WIDTH: multiply lower word, or divide quotient.

## Operation
- **States:**
  - IDLE: start is accepted only here.
    - `start_mult` → MULT.
    - `start_div` → DIV.
    - Both high: `start_mult` wins and `start_div` is dropped.
  - MULT: radix-2 Booth, 32 iterations, then → FINISH.
  - DIV: restoring division on magnitudes, 32 iterations, then → FINISH.
  - FINISH: sign correction, write HI/LO, pulse `done`, then → IDLE.
- **Operand capture:** on accept, `a_in`/`b_in` are latched and the 6-bit iteration counter is cleared. Operand changes after the accept have no effect.
- **Starts while busy:** any start while not in IDLE is ignored; no queueing.
- **Multiply:** full signed 64-bit product; `hi_out` = [63:32], `lo_out` = [31:0].
- **Divide:**
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000 and HI = 0 (wraps; no flag).
- **Result hold:** HI/LO change only in FINISH. They hold their values across IDLE and during a following operation until that operation's FINISH.
- **Reset:** asynchronous, any state.
  - State = IDLE, counter = 0.
  - `busy` = 0, `done` = 0, `div_zero` = 0.
  - `hi_out` = 0, `lo_out` = 0.
  - Internal accumulators = 0.
  - Any in-flight operation is discarded.

## Timing
- **Latency:** start high in cycle 0.
  - `busy` is high in cycles 1–33: 32 iterations plus FINISH.
  - `done` and the new HI/LO are visible in cycle 34.
  - `busy` is low in cycle 34.
- **Back-to-back:** a new start in cycle 34 is accepted, so operations issue every 34 cycles.
- **Registered outputs:** all outputs are registered; none is combinational from the inputs.
- **`done` width:** exactly one cycle per accepted operation; never asserted twice for one start.

## Configuration
- Macro: `MULTDIV_DIVZERO_EN`.
- **Defined:** in DIV, `b_in == 0` is detected at accept.
  - The block goes directly to FINISH.
  - `done` and `div_zero` pulse together in cycle 2.
  - HI/LO are left unchanged.
  - `busy` is high in cycle 1 only.
- **Undefined:**
  - No `div_zero` port logic; the port is tied 0.
  - Division by zero runs the full 34 cycles.
  - Result: LO = 0xFFFFFFFF if the dividend is ≥ 0, else 0x00000001; HI = dividend.

## Structure
- **Package `multdiv_pkg`:**
  - State enum (IDLE, MULT, DIV, FINISH).
  - `MULTDIV_WIDTH` = 32.
  - `MULTDIV_ITERS` = 32.
  - Counter width = 6.
- **Sub-module `multdiv_div_step`:** one combinational restoring-division step. Input is (partial remainder, divisor magnitude, next dividend bit); output is (new remainder, quotient bit). It is instantiated once.
- **Booth step:** stays inline.

## Test plan
- **Multiply:** `start_mult`, A = 7, B = −3 → `done` in cycle 34, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- **Divide:** `start_div`, A = −7, B = 2 → LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). Then `start_mult` in cycle 34 is accepted.
- **Overflow divide:** A = 0x80000000, B = 0xFFFFFFFF → LO = 0x80000000, HI = 0. Also check that `start_div` pulsed in cycle 10 during a running mult is ignored: exactly one `done`, with the mult result.
- **Divide by zero:** A = 5, B = 0.
  - With `MULTDIV_DIVZERO_EN`: `done` and `div_zero` in cycle 2, HI/LO unchanged from the previous op.
  - Without it: cycle 34, LO = 0xFFFFFFFF, HI = 5.
- **Reset mid-operation:** `start_mult`, then drop `reset_in` low in cycle 15 asynchronously (mid-cycle) → immediately `busy` = 0 and HI = LO = 0; no `done` follows after release.
- **Simultaneous starts:** `start_mult` and `start_div` both high, A = 0x00010000, B = 0x00010000 → multiply performed, HI = 1, LO = 0.
